// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between issue logic and alu_seq.
// master = issuer/consumer side, slave = sequencer side.
interface alu_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_sr1;
    logic [31:0] req_sr2;
    logic [2:0]  req_os;
    logic [5:0]  req_shift;
    logic [3:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rd;
    logic        rsp_zero;
    logic [3:0]  rsp_tag;

    modport master (
        output req_valid, req_sr1, req_sr2, req_os, req_shift, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_rd, rsp_zero, rsp_tag,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_sr1, req_sr2, req_os, req_shift, req_tag,
        output req_ready,
        output rsp_valid, rsp_rd, rsp_zero, rsp_tag,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_seq.sv
// ALU operation sequencer: one op in flight, in-order tagged response FIFO.
// Optional zero-flag checker enabled by defining ALU_SEQ_ZCHECK_EN.
module alu_seq #(
    parameter int ALU_LAT = 1,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    alu_seq_if.slave    bus,
    output logic [31:0] alu_sr1,
    output logic [31:0] alu_sr2,
    output logic [2:0]  alu_os,
    output logic [5:0]  alu_shift,
    input  logic [31:0] alu_rd,
    input  logic        alu_zeroflag,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(ALU_LAT + 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] LAT = CW'(ALU_LAT);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPT
    } state_t;

    typedef struct packed {
        logic [31:0] rd;
        logic        zero;
        logic [3:0]  tag;
    } ent_t;

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    tag_q;
    ent_t          mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          accept;
    logic          push;
    logic          pop;

    // req_ready depends only on registered state, never on rsp_ready
    assign bus.req_ready = (state == S_IDLE) && (count < FULL);
    assign pop = bus.rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (accept) nxt = S_WAIT;
            S_WAIT:  if (cnt == ONE) nxt = S_CAPT;
            S_CAPT:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        push   = 1'b0;
        unique case (1'b1)
            (state == S_IDLE): accept = bus.req_valid && bus.req_ready;
            (state == S_CAPT): push = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_sr1   <= '0;
            alu_sr2   <= '0;
            alu_os    <= '0;
            alu_shift <= '0;
            tag_q     <= '0;
            cnt       <= '0;
        end else if (accept) begin
            alu_sr1   <= bus.req_sr1;
            alu_sr2   <= bus.req_sr2;
            alu_os    <= bus.req_os;
            alu_shift <= bus.req_shift;
            tag_q     <= bus.req_tag;
            cnt       <= LAT;
        end else if (state == S_WAIT) begin
            cnt <= cnt - ONE;
        end
    end

    // Only one op in flight, so push never meets a full FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= '{rd: alu_rd, zero: alu_zeroflag, tag: tag_q};
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.rsp_valid = (count != '0);
    assign bus.rsp_rd    = mem[rptr].rd;
    assign bus.rsp_zero  = mem[rptr].zero;
    assign bus.rsp_tag   = mem[rptr].tag;

`ifdef ALU_SEQ_ZCHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (push && (alu_zeroflag != (alu_rd == 32'h0))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table plus handshake corner sequences.
// A small clocked ALU model stands in for the real alu (1-edge latency).
module tb_alu_seq;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if bus();

    logic [31:0] alu_sr1;
    logic [31:0] alu_sr2;
    logic [2:0]  alu_os;
    logic [5:0]  alu_shift;
    logic [31:0] alu_rd = 32'h0;
    logic        alu_zeroflag = 1'b0;
    logic        err;

    alu_seq #(.ALU_LAT(1), .DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .alu_sr1      (alu_sr1),
        .alu_sr2      (alu_sr2),
        .alu_os       (alu_os),
        .alu_shift    (alu_shift),
        .alu_rd       (alu_rd),
        .alu_zeroflag (alu_zeroflag),
        .err          (err)
    );

`ifdef ALU_SEQ_ZCHECK_EN
    localparam logic ZEXP = 1'b1;
`else
    localparam logic ZEXP = 1'b0;
`endif

    logic bad_z = 1'b0;

    function automatic logic [31:0] f(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic [2:0] os,
                                      input logic [5:0] sh);
        case (os)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << sh[4:0];
            3'd6:    return a >> sh[4:0];
            default: return {31'b0, $signed(a) < $signed(b)};
        endcase
    endfunction

    always @(posedge clk) begin
        alu_rd <= f(alu_sr1, alu_sr2, alu_os, alu_shift);
        alu_zeroflag <= bad_z ? 1'b0
                      : (f(alu_sr1, alu_sr2, alu_os, alu_shift) == 32'h0);
    end

    typedef struct packed {
        logic [31:0] rd;
        logic [3:0]  tag;
    } pop_t;

    pop_t pop_q[$];

    always @(posedge clk) begin
        if (bus.rsp_valid && bus.rsp_ready)
            pop_q.push_back('{rd: bus.rsp_rd, tag: bus.rsp_tag});
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] os, input logic [5:0] sh,
                         input logic [3:0] tag);
        int n;
        bus.req_sr1   = a;
        bus.req_sr2   = b;
        bus.req_os    = os;
        bus.req_shift = sh;
        bus.req_tag   = tag;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.req_ready) begin
            chk("issue_timeout", 32'(bus.req_ready), 32'd1);
        end else begin
            tick();
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        if (!bus.rsp_valid)
            chk("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic pop1();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] sr1;
        logic [31:0] sr2;
        logic [2:0]  os;
        logic [5:0]  sh;
        logic [3:0]  tag;
        logic [31:0] exp_rd;
        logic        exp_z;
    } vec_t;

    vec_t vt[9];

    initial begin
        logic seen;
        logic stuck;
        int n;

        vt[0] = '{32'hFFFFFFFF, 32'h1, 3'd0, 6'd0, 4'd1, 32'h0, 1'b1};
        vt[1] = '{32'h10, 32'h3, 3'd1, 6'd0, 4'd2, 32'hD, 1'b0};
        vt[2] = '{32'hF0F0, 32'h0FF0, 3'd2, 6'd0, 4'd4, 32'h00F0, 1'b0};
        vt[3] = '{32'hF000, 32'h000F, 3'd3, 6'd0, 4'd5, 32'hF00F, 1'b0};
        vt[4] = '{32'hAAAA5555, 32'hFFFF0000, 3'd4, 6'd0, 4'd6,
                  32'h55555555, 1'b0};
        vt[5] = '{32'h1, 32'h0, 3'd5, 6'd4, 4'd7, 32'h10, 1'b0};
        vt[6] = '{32'h80000000, 32'h0, 3'd6, 6'd31, 4'd8, 32'h1, 1'b0};
        vt[7] = '{32'hFFFFFFFF, 32'h1, 3'd7, 6'd0, 4'd9, 32'h1, 1'b0};
        vt[8] = '{32'h5, 32'h5, 3'd1, 6'd0, 4'd10, 32'h0, 1'b1};

        bus.req_valid = 1'b0;
        bus.req_sr1   = '0;
        bus.req_sr2   = '0;
        bus.req_os    = '0;
        bus.req_shift = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;

        // reset state
        #12;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_alu_os", 32'(alu_os), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // single op timing
        issue(32'h9, 32'h1, 3'd0, 6'd0, 4'd3);
        chk("one_sr1_c0", alu_sr1, 32'h9);
        chk("one_ready_busy", 32'(bus.req_ready), 32'd0);
        tick();
        chk("one_sr1_c1", alu_sr1, 32'h9);
        chk("one_valid_early", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("one_valid", 32'(bus.rsp_valid), 32'd1);
        chk("one_rd", bus.rsp_rd, 32'hA);
        chk("one_zero", 32'(bus.rsp_zero), 32'd0);
        chk("one_tag", 32'(bus.rsp_tag), 32'd3);
        chk("one_ready_back", 32'(bus.req_ready), 32'd1);
        pop1();
        chk("one_popped", 32'(bus.rsp_valid), 32'd0);

        // vector table
        for (int i = 0; i < 9; i++) begin
            issue(vt[i].sr1, vt[i].sr2, vt[i].os, vt[i].sh, vt[i].tag);
            wait_rsp();
            chk($sformatf("vec%0d_rd", i), bus.rsp_rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_z", i), 32'(bus.rsp_zero), 32'(vt[i].exp_z));
            chk($sformatf("vec%0d_tag", i), 32'(bus.rsp_tag), 32'(vt[i].tag));
            pop1();
        end

        // reset during WAIT discards the op
        issue(32'h77, 32'h1, 3'd0, 6'd0, 4'hE);
        reset = 1'b0;
        #2;
        chk("rst_mid_sr1", alu_sr1, 32'h0);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen |= bus.rsp_valid;
        end
        chk("rst_mid_norsp", 32'(seen), 32'd0);
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);

        // FIFO fill with consumer stalled
        pop_q.delete();
        for (int t = 0; t < 4; t++)
            issue(32'h100 + 32'(t), 32'h0, 3'd0, 6'd0, 4'(t));
        tick();
        tick();
        bus.req_sr1   = 32'h104;
        bus.req_sr2   = 32'h0;
        bus.req_os    = 3'd0;
        bus.req_tag   = 4'd4;
        bus.req_valid = 1'b1;
        stuck = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stuck &= !bus.req_ready;
            tick();
        end
        chk("fill_ready_low", 32'(stuck), 32'd1);
        chk("fill_head_tag", 32'(bus.rsp_tag), 32'd0);
        bus.rsp_ready = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        bus.req_valid = 1'b0;
        n = 0;
        while (pop_q.size() < 5 && n < 30) begin
            tick();
            n++;
        end
        bus.rsp_ready = 1'b0;
        chk("fill_pops", 32'(pop_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < pop_q.size()) begin
                chk($sformatf("fill_tag%0d", i), 32'(pop_q[i].tag), 32'(i));
                chk($sformatf("fill_rd%0d", i), pop_q[i].rd, 32'h100 + 32'(i));
            end
        end

        // push and pop in the same cycle
        issue(32'h1, 32'h1, 3'd0, 6'd0, 4'hA);
        wait_rsp();
        issue(32'h2, 32'h1, 3'd0, 6'd0, 4'hB);
        tick();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("pp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("pp_tag", 32'(bus.rsp_tag), 32'hB);
        chk("pp_rd", bus.rsp_rd, 32'h3);
        pop1();
        chk("pp_count1", 32'(bus.rsp_valid), 32'd0);

        // zero-flag checker
        bad_z = 1'b1;
        issue(32'h0, 32'h0, 3'd0, 6'd0, 4'd5);
        wait_rsp();
        bad_z = 1'b0;
        chk("zc_rd", bus.rsp_rd, 32'h0);
        chk("zc_zero_raw", 32'(bus.rsp_zero), 32'd0);
        chk("zc_err", 32'(err), 32'(ZEXP));
        pop1();
        issue(32'h1, 32'h2, 3'd0, 6'd0, 4'd6);
        wait_rsp();
        chk("zc_err_sticky", 32'(err), 32'(ZEXP));
        pop1();

        // pointer wrap
        pop_q.delete();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++)
            issue(32'(i), 32'd100, 3'd0, 6'd0, 4'(i));
        n = 0;
        while (pop_q.size() < 10 && n < 20) begin
            tick();
            n++;
        end
        bus.rsp_ready = 1'b0;
        chk("wrap_pops", 32'(pop_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < pop_q.size()) begin
                chk($sformatf("wrap_tag%0d", i), 32'(pop_q[i].tag), 32'(i));
                chk($sformatf("wrap_rd%0d", i), pop_q[i].rd, 32'(i) + 32'd100);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
